// File: rtl/seg7_scan_rx.sv
`timescale 1ns/1ps
// seg7_scan_rx
//   Receive side of a multiplexed 7-segment display link. The active-low
//   segment bus and digit selects from a scanning driver are synchronized.
//   A select/pattern pair must hold for STABLE_CYC cycles before it is
//   accepted. Each accepted pair is decoded back into a hex nibble for the
//   selected digit.
//
//   Optional feature: define SEG7_RX_DP_EN to add the decimal-point input
//   dp_in and the per-digit output dp_out.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   seg_in     segment bus, active-low, bit0=a .. bit6=g (async to clk)
//   an_in      digit selects, active-low, at most one low (async to clk)
//   dp_in      decimal point, active-low (SEG7_RX_DP_EN only)
//   dp_out     per-digit decimal point, active-high (SEG7_RX_DP_EN only)
//   value      decoded nibbles, digit i at [4i+3:4i]
//   dig_vld    bit i set when the last accepted pattern for digit i was legal
//   frame_stb  one-cycle pulse once every digit has been accepted since the last pulse
//   err        one-cycle pulse when an accepted pattern is not a hex glyph
module seg7_scan_rx #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [NDIG-1:0]     an_in,
`ifdef SEG7_RX_DP_EN
  input  logic                dp_in,
  output logic [NDIG-1:0]     dp_out,
`endif
  output logic [4*NDIG-1:0]   value,
  output logic [NDIG-1:0]     dig_vld,
  output logic                frame_stb,
  output logic                err
);

`ifdef SEG7_RX_DP_EN
  localparam int PW = 8 + NDIG;
`else
  localparam int PW = 7 + NDIG;
`endif

  logic [6:0]      seg_s1, seg_s2;
  logic [NDIG-1:0] an_s1, an_s2;
`ifdef SEG7_RX_DP_EN
  logic            dp_s1, dp_s2;
`endif

  logic [PW-1:0]    pair, pair_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [NDIG-1:0]  sel, seen, seen_nxt;
  logic             one_sel, accept;
  logic [4:0]       dec;

  // Returns {legal, nibble}. A fully blank digit is a legal zero.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1111111, 7'b1000000: seg_decode = {1'b1, 4'h0};
      7'b1111001: seg_decode = {1'b1, 4'h1};
      7'b0100100: seg_decode = {1'b1, 4'h2};
      7'b0110000: seg_decode = {1'b1, 4'h3};
      7'b0011001: seg_decode = {1'b1, 4'h4};
      7'b0010010: seg_decode = {1'b1, 4'h5};
      7'b0000010: seg_decode = {1'b1, 4'h6};
      7'b1111000: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0010000: seg_decode = {1'b1, 4'h9};
      7'b0001000: seg_decode = {1'b1, 4'hA};
      7'b0000011: seg_decode = {1'b1, 4'hB};
      7'b1000110: seg_decode = {1'b1, 4'hC};
      7'b0100001: seg_decode = {1'b1, 4'hD};
      7'b0000110: seg_decode = {1'b1, 4'hE};
      7'b0001110: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = 5'b0_0000;
    endcase
  endfunction

`ifdef SEG7_RX_DP_EN
  assign pair = {dp_s2, an_s2, seg_s2};
`else
  assign pair = {an_s2, seg_s2};
`endif

  always_comb begin
    // The counter passes STABLE_CYC-1 only once per pair (it saturates well
    // above that value), so comparing against the next value gives a single
    // accept with no extra "done" flag.
    cnt_nxt  = (pair != pair_q) ? '0 : ((cnt == '1) ? cnt : cnt + 1'b1);
    sel      = ~an_s2;
    one_sel  = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    accept   = one_sel && (cnt_nxt == CNT_W'(STABLE_CYC - 1));
    dec      = seg_decode(seg_s2);
    seen_nxt = seen | sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1    <= '1;
      seg_s2    <= '1;
      an_s1     <= '1;
      an_s2     <= '1;
`ifdef SEG7_RX_DP_EN
      dp_s1     <= 1'b1;
      dp_s2     <= 1'b1;
      dp_out    <= '0;
`endif
      pair_q    <= '1;
      cnt       <= '0;
      seen      <= '0;
      value     <= '0;
      dig_vld   <= '0;
      frame_stb <= 1'b0;
      err       <= 1'b0;
    end else begin
      seg_s1    <= seg_in;
      seg_s2    <= seg_s1;
      an_s1     <= an_in;
      an_s2     <= an_s1;
`ifdef SEG7_RX_DP_EN
      dp_s1     <= dp_in;
      dp_s2     <= dp_s1;
`endif
      pair_q    <= pair;
      cnt       <= cnt_nxt;
      frame_stb <= 1'b0;
      err       <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NDIG; i++) begin
          if (sel[i]) begin
            if (dec[4]) value[4*i +: 4] <= dec[3:0];
            dig_vld[i] <= dec[4];
`ifdef SEG7_RX_DP_EN
            dp_out[i]  <= ~dp_s2;
`endif
          end
        end
        err <= ~dec[4];
        // The digit that completes the set starts the next frame empty.
        if (&seen_nxt) begin
          frame_stb <= 1'b1;
          seen      <= '0;
        end else begin
          seen      <= seen_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_rx.sv
`timescale 1ns/1ps
module tb_seg7_scan_rx;
  localparam int NDIG = 4;
  localparam int S    = 8;
  localparam int PW   = 7 + NDIG + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic        dp_in;
  logic [15:0] value;
  logic [3:0]  dig_vld;
  logic        frame_stb, err;
`ifdef SEG7_RX_DP_EN
  logic [3:0]  dp_out;
`endif

  seg7_scan_rx #(.NDIG(NDIG), .STABLE_CYC(S), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .an_in     (an_in),
`ifdef SEG7_RX_DP_EN
    .dp_in     (dp_in),
    .dp_out    (dp_out),
`endif
    .value     (value),
    .dig_vld   (dig_vld),
    .frame_stb (frame_stb),
    .err       (err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int frame_seen = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pair is taken when the pin history shows the same
  // {dp,an,seg} for exactly S consecutive samples, ending two samples back
  // (the synchronizer depth).
  logic [6:0]    seg_tbl [16];
  logic [PW-1:0] hist [0:S+2];
  logic [15:0]   m_value;
  logic [3:0]    m_vld, m_seen, m_dp;
  logic          m_frame, m_err;
  bit            started = 0;

  initial seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [4:0] m_decode(input logic [6:0] s);
    if (s == 7'h7F) return 5'h10;
    for (int n = 0; n < 16; n++)
      if (seg_tbl[n] == s) return {1'b1, 4'(n)};
    return 5'h00;
  endfunction

  always @(posedge clk) begin
    logic [PW-1:0] p;
    logic [4:0]    r;
    int            lows, d;
    bit            steady;
    started = 1;
    p = {dp_in, an_in, seg_in};
    if (rst) begin
      for (int j = 0; j <= S + 2; j++) hist[j] = '1;
      m_value = '0; m_vld = '0; m_seen = '0; m_dp = '0;
      m_frame = 1'b0; m_err = 1'b0;
    end else begin
      for (int j = S + 2; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = p;
      m_frame = 1'b0;
      m_err   = 1'b0;
      steady  = 1;
      for (int j = 3; j <= S + 1; j++) if (hist[j] != hist[2]) steady = 0;
      if (steady && hist[S+2] != hist[2]) begin
        lows = 0; d = 0;
        for (int i = 0; i < NDIG; i++) if (!hist[2][7+i]) begin lows++; d = i; end
        if (lows == 1) begin
          r = m_decode(hist[2][6:0]);
          if (r[4]) m_value[4*d +: 4] = r[3:0];
          m_vld[d] = r[4];
          m_err    = !r[4];
          m_dp[d]  = ~hist[2][PW-1];
          m_seen[d] = 1'b1;
          if (&m_seen) begin m_frame = 1'b1; m_seen = '0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("value", 32'(value), 32'(m_value));
      check("dig_vld", 32'(dig_vld), 32'(m_vld));
      check("frame_stb", 32'(frame_stb), 32'(m_frame));
      check("err", 32'(err), 32'(m_err));
`ifdef SEG7_RX_DP_EN
      check("dp_out", 32'(dp_out), 32'(m_dp));
`endif
      if (frame_stb === 1'b1) frame_seen++;
      if (err === 1'b1) err_seen++;
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    @(posedge clk); #1;
    an_in  = an;
    seg_in = seg;
  endtask

  task automatic scan();
    drive(4'b1110, 7'b1111001); repeat (11) @(posedge clk);
    drive(4'b1101, 7'b0100100); repeat (11) @(posedge clk);
    drive(4'b1011, 7'b0110000); repeat (11) @(posedge clk);
    drive(4'b0111, 7'b1000110); repeat (11) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0, e0, lat;
    rst = 1'b1; seg_in = 7'h7F; an_in = 4'hF; dp_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_value", 32'(value), 32'h0);
    check("reset_vld", 32'(dig_vld), 32'h0);

    // idle
    f0 = frame_seen; e0 = err_seen;
    repeat (100) @(posedge clk);
    #1;
    check("idle_frames", 32'(frame_seen - f0), 32'd0);
    check("idle_errs", 32'(err_seen - e0), 32'd0);
    check("idle_value", 32'(value), 32'h0);

    // single digit, latency
    drive(4'b1110, 7'b0100100);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (lat == 0 && dig_vld[0]) lat = k;
    end
    check("accept_latency", 32'(lat), 32'(S + 2));
    check("digit0_value", 32'(value[3:0]), 32'h2);
    check("digit0_vld", 32'(dig_vld), 32'h1);
    check("model_digit0", 32'(m_value[3:0]), 32'h2);

    // full scans
    f0 = frame_seen;
    scan();
    check("frame_count1", 32'(frame_seen - f0), 32'd1);
    check("scan_value", 32'(value), 32'hC321);
    check("scan_vld", 32'(dig_vld), 32'hF);
    check("model_scan", 32'(m_value), 32'hC321);
    scan();
    check("frame_count2", 32'(frame_seen - f0), 32'd2);

    // glitching pattern never settles
    for (int g = 0; g < 8; g++) begin
      drive(4'b1110, (g % 2 == 0) ? 7'b0011001 : 7'b0110000);
      repeat (4) @(posedge clk);
    end
    drive(4'hF, 7'h7F);
    repeat (12) @(posedge clk);
    #1;
    check("glitch_value", 32'(value), 32'hC321);

    // illegal pattern
    e0 = err_seen;
    drive(4'b1101, 7'b0101010);
    repeat (20) @(posedge clk);
    #1;
    check("err_pulses", 32'(err_seen - e0), 32'd1);
    check("err_vld", 32'(dig_vld), 32'hD);
    check("err_hold", 32'(value[7:4]), 32'h2);

    // reset while a new pair is settling
    drive(4'b1011, 7'b0011001);
`ifdef SEG7_RX_DP_EN
    dp_in = 1'b0;
`endif
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_vld", 32'(dig_vld), 32'h0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (lat == 0 && dig_vld[2]) lat = k;
    end
    check("rst_latency", 32'(lat), 32'(S + 2));
    check("rst_digit2", 32'(value), 32'h0400);
`ifdef SEG7_RX_DP_EN
    check("dp_digit2", 32'(dp_out), 32'h4);
`endif

    drive(4'hF, 7'h7F);
    repeat (5) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
